// File: rtl/display_bcd_converter.sv
// ---------------------------------------------------------------------------
// display_bcd_converter
//   Converts a 16-bit unsigned binary value into four BCD digits for a
//   7-segment style display, using a sequential double-dabble engine
//   (one bit per clock, 16 shift cycles per conversion).
//
// Handshake: a request is taken on a rising edge where start=1 and the FSM is
//   in IDLE; value is captured on that same edge only. Requests arriving in
//   SHIFT or DONE are dropped, never queued. busy is high while shifting,
//   and done pulses for one cycle when data_0..data_3 have been written.
//
// Ports
//   clock      : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : conversion request
//   value[15:0]: binary input, sampled with an accepted start
//   data_0..3  : registered BCD digits (ones..thousands)
//   busy       : conversion in progress
//   done       : one-cycle pulse when new digits are written
//   overflow   : last accepted value exceeded 9999
//   dbg_state  : current FSM state encoding (0=IDLE, 1=SHIFT, 2=DONE)
// ---------------------------------------------------------------------------
module display_bcd_converter #(
  parameter logic [3:0] OVF_CODE = 4'hF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic [3:0]  data_0,
  output logic [3:0]  data_1,
  output logic [3:0]  data_2,
  output logic [3:0]  data_3,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] MAX_VALUE = 16'd9999;

  state_t      state_q;
  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [4:0]  cnt_q;
  logic [15:0] data_q;   // {thousands, hundreds, tens, ones}
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;

  // One double-dabble step: correct every nibble >= 5, then shift the
  // concatenated {bcd, bin} pair left by one bit.
  logic [15:0] bcd_adj;
  logic [31:0] dd_shift;
  logic [15:0] bcd_d;
  logic [15:0] bin_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    dd_shift = {bcd_adj[14:0], bin_q, 1'b0};
    bcd_d    = dd_shift[31:16];
    bin_d    = dd_shift[15:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (value > MAX_VALUE) begin
              // Out of display range: skip the shifter entirely.
              data_q  <= {4{OVF_CODE}};
              ovf_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              bin_q   <= value;
              bcd_q   <= '0;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 5'd1;
          // Last of 16 steps: publish the result in the same edge so the
          // display never shows intermediate scratch contents.
          if (cnt_q == 5'd15) begin
            data_q  <= bcd_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_0    = data_q[3:0];
  assign data_1    = data_q[7:4];
  assign data_2    = data_q[11:8];
  assign data_3    = data_q[15:12];
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_display_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_display_bcd_converter
//   Directed bench for display_bcd_converter. Inputs are driven on the
//   falling edge, outputs sampled on the falling edge; expected digits are
//   hand-computed BCD constants.
// ---------------------------------------------------------------------------
module tb_display_bcd_converter;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] value;
  logic [3:0]  data_0;
  logic [3:0]  data_1;
  logic [3:0]  data_2;
  logic [3:0]  data_3;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [1:0]  dbg_state;
  logic [15:0] digits;

  int n_checks = 0;
  int n_fail   = 0;

  assign digits = {data_3, data_2, data_1, data_0};

  display_bcd_converter #(.OVF_CODE(4'hF)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .value     (value),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and follow it to its done pulse.
  // exp_lat = falling edges from E0 to the done sample (16 valid, 0 overflow).
  task automatic run_conv(input string name, input logic [15:0] v,
                          input logic [15:0] exp_d, input logic exp_ovf,
                          input int exp_lat);
    logic [15:0] prev;
    int cyc;
    int bad_busy;
    int bad_hold;
    prev     = digits;
    cyc      = 0;
    bad_busy = 0;
    bad_hold = 0;
    start = 1'b1;
    value = v;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    value = ~v;   // must not disturb the conversion in progress
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) bad_busy++;
      if (digits !== prev) bad_hold++;
      @(negedge clock);
      cyc++;
    end
    check_eq({name, "_latency"}, cyc, exp_lat);
    check_eq({name, "_busy_shift"}, bad_busy, 0);
    check_eq({name, "_digits_hold"}, bad_hold, 0);
    check_eq({name, "_busy_done"}, {31'd0, busy}, 0);
    check_eq({name, "_digits"}, {16'd0, digits}, {16'd0, exp_d});
    check_eq({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    @(negedge clock);
    check_eq({name, "_done_width"}, {31'd0, done}, 0);
    check_eq({name, "_ovf_hold"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    int cyc;
    int cnt;

    // Reset held with a pending request
    reset_n = 1'b0;
    start   = 1'b1;
    value   = 16'd1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("rst_digits", {16'd0, digits}, 0);
      check_eq("rst_busy", {31'd0, busy}, 0);
      check_eq("rst_done", {31'd0, done}, 0);
      check_eq("rst_ovf", {31'd0, overflow}, 0);
      check_eq("rst_state", {30'd0, dbg_state}, 0);
    end
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("post_rst_busy", {31'd0, busy}, 0);

    // Normal conversions and range boundaries
    run_conv("v1234", 16'd1234, 16'h1234, 1'b0, 16);
    run_conv("v9999", 16'd9999, 16'h9999, 1'b0, 16);
    run_conv("v0", 16'd0, 16'h0000, 1'b0, 16);
    run_conv("v10000", 16'd10000, 16'hFFFF, 1'b1, 0);
    run_conv("vFFFF", 16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_conv("v42", 16'd42, 16'h0042, 1'b0, 16);
    run_conv("v5678", 16'd5678, 16'h5678, 1'b0, 16);

    // Start asserted during SHIFT is dropped
    start = 1'b1;
    value = 16'd1234;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1;
    value = 16'd5678;
    repeat (5) @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("ignore_latency", cyc, 6);
    check_eq("ignore_digits", {16'd0, digits}, 32'h1234);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy !== 1'b0) cnt++;
    end
    check_eq("ignore_no_restart", cnt, 0);
    check_eq("ignore_digits_kept", {16'd0, digits}, 32'h1234);

    // Reset mid-conversion
    start = 1'b1;
    value = 16'd4321;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("abort_digits", {16'd0, digits}, 0);
    check_eq("abort_busy", {31'd0, busy}, 0);
    check_eq("abort_state", {30'd0, dbg_state}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
    end
    check_eq("abort_no_done", cnt, 0);
    run_conv("v4321", 16'd4321, 16'h4321, 1'b0, 16);

    // Back-to-back with start held high: valid values
    start = 1'b1;
    value = 16'd7;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (done !== 1'b1 && cyc < 40);
    check_eq("b2b_period", cyc, 18);
    check_eq("b2b_digits", {16'd0, digits}, 32'h0007);
    start = 1'b0;
    repeat (25) @(negedge clock);

    // Back-to-back with start held high: overflow values
    start = 1'b1;
    value = 16'd20000;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    cyc = 0;
    cnt = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (busy !== 1'b0) cnt++;
    end while (done !== 1'b1 && cyc < 40);
    check_eq("b2b_ovf_period", cyc, 2);
    check_eq("b2b_ovf_busy", cnt, 0);
    check_eq("b2b_ovf_digits", {16'd0, digits}, 32'hFFFF);
    check_eq("b2b_ovf_flag", {31'd0, overflow}, 1);
    start = 1'b0;
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_bcd_converter.md
DISPLAY_BCD_CONVERTER -- requirements
Module: display_bcd_converter

Interface
REQ-001 SHALL have parameter OVF_CODE, default 4'hF, the digit code driven on all four digits when the input exceeds 9999.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  conversion request, sampled on rising clock edge.
REQ-005 SHALL have port value  input  16  unsigned binary value to convert, sampled with start.
REQ-006 SHALL have port data_0  output  4  BCD ones digit, registered.
REQ-007 SHALL have port data_1  output  4  BCD tens digit, registered.
REQ-008 SHALL have port data_2  output  4  BCD hundreds digit, registered.
REQ-009 SHALL have port data_3  output  4  BCD thousands digit, registered.
REQ-010 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when new digits have been written.
REQ-012 SHALL have port overflow  output  1  high when the last accepted value exceeded 9999.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL accept start only in IDLE; start in SHIFT or DONE SHALL be ignored, not queued.
REQ-015 On the accepting edge E0 with value <= 9999: load value into a 16-bit binary shift register, clear a 16-bit BCD scratch register, clear the 5-bit shift counter, clear overflow, go to SHIFT.
REQ-016 Each SHIFT edge SHALL add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by one bit, then increment the counter.
REQ-017 The double-dabble algorithm SHALL run exactly 16 SHIFT edges (E1..E16); on E16 data_0..data_3 SHALL load the corrected scratch nibbles (ones..thousands) and the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle (between E16 and E17), with done=1; on E17 the FSM SHALL return to IDLE.
REQ-019 busy SHALL be 1 in SHIFT only (cycles after E0 through E16), 0 in IDLE and DONE.
REQ-020 data_0..data_3 SHALL hold the previous result unchanged during SHIFT (no intermediate values visible).
REQ-021 On the accepting edge with value > 9999: data_0..data_3 SHALL load OVF_CODE, overflow SHALL be set, the FSM SHALL go directly to DONE (done high in the cycle after E0, busy never asserted).
REQ-022 overflow SHALL hold its value until the next accepted start.
REQ-023 start held high continuously SHALL produce back-to-back conversions, one accepted per IDLE visit (every 18 cycles for valid values, every 2 for overflow values).
REQ-024 value SHALL be sampled only on the accepting edge; later changes on value SHALL NOT affect the conversion in progress.

Reset
REQ-025 reset_n low SHALL immediately, without a clock edge, force state IDLE, data_0..data_3=0, busy=0, done=0, overflow=0, counter and shift registers=0.
REQ-026 Reset during SHIFT or DONE SHALL abort the conversion; no done pulse SHALL follow, and the first start accepted after reset_n rises SHALL convert normally.

Verification
REQ-027 Reset: hold reset_n=0 with start=1, value=1234 -> all digits 0, busy=0, done=0, overflow=0 throughout.
REQ-028 value=1234, start pulsed at E0 -> busy high E0..E16, digits stay previous until E16, then data_3..data_0=1,2,3,4, done=1 for exactly one cycle, overflow=0.
REQ-029 value=9999 then value=0 -> digits 9,9,9,9 then 0,0,0,0, overflow=0 both times.
REQ-030 value=10000 (and value=16'hFFFF) -> digits all 4'hF, overflow=1, done one cycle after E0, busy never high; a following value=42 -> digits 0,0,4,2, overflow=0.
REQ-031 value=1234 accepted, then start=1 with value=5678 at cycle 5 of SHIFT -> result 1,2,3,4; 5678 not converted unless start is high again in IDLE.
REQ-032 reset_n pulsed low at SHIFT cycle 8 of value=4321 -> digits 0,0,0,0 immediately, no done pulse; a following start with value=4321 -> 4,3,2,1.
